channel_accum_engine: RTL

CHANNEL_ACCUM_ENGINE -- requirements
Module: channel_accum_engine

---
 rtl/channel_accum_engine.sv | 86 ++++++++
 1 files changed

// File: rtl/channel_accum_engine.sv
// channel_accum_engine: per-lane signed channel accumulator for int4/int8 patches; CHN_ACC_SAT_EN selects saturating lanes.
module channel_accum_engine #(
  parameter int LANES = 64,
  parameter int IN_W = 4,
  parameter int ACC_W = 20,
  parameter int CNT_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic                   start,
  input  logic [CNT_W-1:0]       chn_num,
  input  logic                   quant_mode,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [LANES*ACC_W-1:0] out_data,
  output logic                   busy,
  output logic                   ovf,
  output logic                   done
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, next;
  logic [CNT_W:0] cnt, target;
  logic mode, take, last, go, ack;
  logic [LANES*ACC_W-1:0] acc, acc_next;
  logic [LANES-1:0] lane_ovf;
  assign in_rdy = state == ACCUM && clk_en;
  assign out_vld = state == HOLD;
  assign busy = state != IDLE;
  assign out_data = acc;
  assign take = in_vld && in_rdy;
  assign last = cnt == target - 1'b1;
  assign go = state == IDLE && start && clk_en;
  assign ack = state == HOLD && out_rdy && clk_en;
  always_comb begin
    next = state;
    next = go ? (chn_num == '0 ? HOLD : ACCUM) : (take && last) ? HOLD : ack ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= next;
  end
  // int8 beats alternate: even = unsigned low nibble, odd = signed high nibble
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [IN_W-1:0] x;
    logic [ACC_W-1:0] a, add;
    logic [ACC_W:0] s;
    assign x = in_data[i*IN_W +: IN_W];
    assign a = acc[i*ACC_W +: ACC_W];
    assign add = !mode ? ACC_W'(x) : cnt[0] ? ACC_W'(x) <<< IN_W : ACC_W'($unsigned(x));
    assign s = {a[ACC_W-1], a} + {add[ACC_W-1], add};
    assign lane_ovf[i] = s[ACC_W] ^ s[ACC_W-1];
`ifdef CHN_ACC_SAT_EN
    assign acc_next[i*ACC_W +: ACC_W] = !lane_ovf[i] ? s[ACC_W-1:0] :
      s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign acc_next[i*ACC_W +: ACC_W] = s[ACC_W-1:0];
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      target <= '0;
      mode <= 1'b0;
      ovf <= 1'b0;
      done <= 1'b0;
    end else if (clk_en) begin
      done <= ack;
      if (go) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
        mode <= quant_mode;
        target <= quant_mode ? {chn_num, 1'b0} : {1'b0, chn_num};
      end else if (take) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
        ovf <= ovf | (|lane_ovf);
      end
    end
  end
endmodule
